exe_pipe: RTL and testbench
===========================

EXE_PIPE -- requirements
Module: exe_pipe

Interface
REQ-001 Parameter XLEN, default 32, operand/result width.
REQ-002 Parameter REG_ADDR_W, default 5, register address width.
REQ-003 Parameter ALUOP_W, default 8, ALU opcode width.
REQ-004 clk_i_EXE  in  1  single clock, all state on rising edge.
REQ-005 rst_n_i_EXE  in  1  reset, asynchronous, active-low.
REQ-006 flush_i_EXE  in  1  synchronous kill of in-flight and held work.
REQ-007 in_valid_i_EXE / in_ready_o_EXE  in/out  1  upstream handshake.
REQ-008 ALUOp_i_EXE  in  ALUOP_W  operation; regWrite_i_EXE  in  1  write request.
REQ-009 Rd_Data1_i_EXE, Rd_Data2_i_EXE, immSignExtend_i_EXE  in  XLEN  rs1, rs2, sign-extended imm.
REQ-010 Wt_Addr_i_EXE  in  REG_ADDR_W  destination register.
REQ-011 out_valid_o_EXE / out_ready_i_EXE  out/in  1  downstream handshake.
REQ-012 Wt_Data_o_EXE  out  XLEN; Wt_Addr_o_EXE  out  REG_ADDR_W; Wt_Enable_o_EXE  out  1.
REQ-013 Rd_Data2_o_EXE  out  XLEN  rs2 pass-through (store data); illegal_o_EXE  out  1  unknown opcode flag; busy_o_EXE  out  1  multiply in progress.

Function
REQ-014 Transfer occurs when valid and ready both high on a rising edge; either side alone changes nothing.
REQ-015 Ops: ORI, ANDI, XORI, ADDI (rs1 op imm); ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU (rs1 op rs2); MUL (low XLEN), MULHU (high XLEN, unsigned).
REQ-016 Shift amount is rs2[$clog2(XLEN)-1:0]; SLT/SLTU result is zero-extended 1 or 0; ADD/SUB wrap modulo 2^XLEN.
REQ-017 Single-cycle ops: result registered, out_valid high the cycle after acceptance (latency 1).
REQ-018 MUL/MULHU: iterative shift-add, XLEN iteration cycles after acceptance, out_valid on cycle XLEN+1; busy_o high during iterations.
REQ-019 FSM states IDLE, MUL_RUN, HOLD; IDLE->MUL_RUN on accepted MUL/MULHU; MUL_RUN->HOLD when iteration count reaches XLEN; HOLD->IDLE when output taken.
REQ-020 Single-cycle result with out_ready low also enters HOLD; outputs stable while held.
REQ-021 in_ready = (state IDLE) and (not out_valid or out_ready), permitting back-to-back single-cycle ops at one per cycle.
REQ-022 Unknown opcode: Wt_Data 0, Wt_Enable 0, illegal_o 1, delivered with latency 1 via normal handshake.
REQ-023 Wt_Enable_o = registered regWrite, forced 0 when Wt_Addr is 0 or opcode illegal.
REQ-024 flush high: next edge clears out_valid, aborts MUL_RUN, returns to IDLE; flush overrides a simultaneous acceptance (input dropped).
REQ-025 Rd_Data2_o and Wt_Addr_o are captured at acceptance and held with the result.

Reset
REQ-026 Reset low asynchronously forces state IDLE, iteration counter 0, out_valid 0, all data/address outputs 0, Wt_Enable 0, illegal 0, busy 0.
REQ-027 Reset asserted mid-multiply discards the operation; no result is delivered after release.
REQ-028 in_ready_o is 0 while reset is low, 1 in the first cycle after release.

Structure
REQ-029 Opcode encodings, XLEN default, and zero/enable constants live in define.v, shared with decode.
REQ-030 Iterative multiplier is one sub-module, exe_mul_iter (start, operands, done, 2*XLEN product).
REQ-031 ALU datapath is combinational inside exe_pipe; only the output register and FSM are sequential.

Verification
REQ-032 ORI rs1=0x0000_00F0, imm=0x0000_000F, rd=3, out_ready=1 -> next cycle Wt_Data=0x0000_00FF, Wt_Addr=3, Wt_Enable=1.
REQ-033 MUL 0xFFFF_FFFF x 2, rd=5 -> busy for 32 cycles, out_valid cycle 33, Wt_Data=0xFFFF_FFFE; MULHU same operands -> 0x0000_0001.
REQ-034 ADD then SUB back-to-back with out_ready held low 3 cycles -> ADD result stable 3 cycles, in_ready 0, SUB delivered one cycle after ADD transfer.
REQ-035 Opcode 0xFF, regWrite=1 -> illegal_o=1, Wt_Enable=0, Wt_Data=0; ADDI to rd=0 -> Wt_Enable=0.
REQ-036 Flush at MUL iteration 10, and reset low at iteration 20 of a second MUL -> no out_valid, state IDLE, in_ready 1 next cycle.
REQ-037 SRA 0x8000_0000 by 31 -> 0xFFFF_FFFF; SLT -1 vs 1 -> 1; SLTU -1 vs 1 -> 0; XLEN=64 build passes same cases sign-extended.

Source files
------------

// File: rtl/exe_pipe_pkg.sv
// Shared execute-stage constants: opcode encodings, FSM states and enable levels.
// The decode stage imports the same package so both sides agree on encodings.
package exe_pipe_pkg;

    localparam int unsigned XLEN_DEF       = 32;
    localparam int unsigned REG_ADDR_W_DEF = 5;
    localparam int unsigned ALUOP_W_DEF    = 8;

    localparam logic WEN_OFF = 1'b0;
    localparam logic WEN_ON  = 1'b1;

    typedef enum logic [7:0] {
        OP_ORI   = 8'h01,
        OP_ANDI  = 8'h02,
        OP_XORI  = 8'h03,
        OP_ADDI  = 8'h04,
        OP_ADD   = 8'h10,
        OP_SUB   = 8'h11,
        OP_AND   = 8'h12,
        OP_OR    = 8'h13,
        OP_XOR   = 8'h14,
        OP_SLL   = 8'h15,
        OP_SRL   = 8'h16,
        OP_SRA   = 8'h17,
        OP_SLT   = 8'h18,
        OP_SLTU  = 8'h19,
        OP_MUL   = 8'h20,
        OP_MULHU = 8'h21
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MUL_RUN = 2'd1,
        S_HOLD    = 2'd2
    } exe_state_e;

endpackage

// File: rtl/exe_mul_iter.sv
// Iterative unsigned shift-add multiplier, one partial product per run cycle.
// o_product_c/o_done_c show the value after the current iteration so the caller can register it.
module exe_mul_iter
    import exe_pipe_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic                i_run,
    input  logic [XLEN-1:0]     i_a,
    input  logic [XLEN-1:0]     i_b,
    output logic                o_done_c,
    output logic [2*XLEN-1:0]   o_product_c
);

    localparam int unsigned CNT_W = $clog2(XLEN) + 1;

    logic [CNT_W-1:0]  r_cnt;
    logic [2*XLEN-1:0] r_acc;
    logic [2*XLEN-1:0] r_mcand;
    logic [XLEN-1:0]   r_mplier;

    assign o_product_c = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign o_done_c    = i_run && (r_cnt == CNT_W'(XLEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_start) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= {{XLEN{1'b0}}, i_a};
            r_mplier <= i_b;
        end else if (i_run) begin
            r_cnt    <= r_cnt + CNT_W'(1);
            r_acc    <= o_product_c;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

endmodule

// File: rtl/exe_pipe.sv
// Execute stage: combinational ALU, iterative multiplier, registered result with
// valid/ready handshake on both sides and a three-state control FSM.
module exe_pipe
    import exe_pipe_pkg::*;
#(
    parameter int unsigned XLEN       = XLEN_DEF,
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int unsigned ALUOP_W    = ALUOP_W_DEF
) (
    input  logic                  clk_i_EXE,
    input  logic                  rst_n_i_EXE,
    input  logic                  flush_i_EXE,
    input  logic                  in_valid_i_EXE,
    output logic                  in_ready_o_EXE,
    input  logic [ALUOP_W-1:0]    ALUOp_i_EXE,
    input  logic                  regWrite_i_EXE,
    input  logic [XLEN-1:0]       Rd_Data1_i_EXE,
    input  logic [XLEN-1:0]       Rd_Data2_i_EXE,
    input  logic [XLEN-1:0]       immSignExtend_i_EXE,
    input  logic [REG_ADDR_W-1:0] Wt_Addr_i_EXE,
    output logic                  out_valid_o_EXE,
    input  logic                  out_ready_i_EXE,
    output logic [XLEN-1:0]       Wt_Data_o_EXE,
    output logic [REG_ADDR_W-1:0] Wt_Addr_o_EXE,
    output logic                  Wt_Enable_o_EXE,
    output logic [XLEN-1:0]       Rd_Data2_o_EXE,
    output logic                  illegal_o_EXE,
    output logic                  busy_o_EXE
);

    localparam int unsigned SHAMT_W = $clog2(XLEN);

    exe_state_e            r_state, w_state_nxt;
    logic                  r_out_valid, w_out_valid_nxt;
    logic [XLEN-1:0]       r_wt_data, w_wt_data_nxt;
    logic [REG_ADDR_W-1:0] r_wt_addr, w_wt_addr_nxt;
    logic                  r_wt_en, w_wt_en_nxt;
    logic [XLEN-1:0]       r_rd_data2, w_rd_data2_nxt;
    logic                  r_illegal, w_illegal_nxt;
    logic                  r_mulhu, w_mulhu_nxt;

    logic                  w_accept, w_take;
    logic                  w_is_mul, w_is_mulhu, w_illegal;
    logic                  w_mul_start, w_mul_run, w_mul_done;
    logic [XLEN-1:0]       w_alu;
    logic [2*XLEN-1:0]     w_product;
    logic [SHAMT_W-1:0]    w_shamt;

    // Reset gates ready so nothing is accepted until reset is released.
    assign in_ready_o_EXE = rst_n_i_EXE && (r_state == S_IDLE) && (!r_out_valid || out_ready_i_EXE);
    assign w_accept       = in_valid_i_EXE && in_ready_o_EXE && !flush_i_EXE;
    assign w_take         = r_out_valid && out_ready_i_EXE;
    assign w_shamt        = Rd_Data2_i_EXE[SHAMT_W-1:0];
    assign w_mul_run      = (r_state == S_MUL_RUN) && !flush_i_EXE;

    always_comb begin
        w_alu      = '0;
        w_illegal  = 1'b0;
        w_is_mul   = 1'b0;
        w_is_mulhu = 1'b0;
        case (ALUOp_i_EXE)
            ALUOP_W'(OP_ORI):   w_alu = Rd_Data1_i_EXE | immSignExtend_i_EXE;
            ALUOP_W'(OP_ANDI):  w_alu = Rd_Data1_i_EXE & immSignExtend_i_EXE;
            ALUOP_W'(OP_XORI):  w_alu = Rd_Data1_i_EXE ^ immSignExtend_i_EXE;
            ALUOP_W'(OP_ADDI):  w_alu = Rd_Data1_i_EXE + immSignExtend_i_EXE;
            ALUOP_W'(OP_ADD):   w_alu = Rd_Data1_i_EXE + Rd_Data2_i_EXE;
            ALUOP_W'(OP_SUB):   w_alu = Rd_Data1_i_EXE - Rd_Data2_i_EXE;
            ALUOP_W'(OP_AND):   w_alu = Rd_Data1_i_EXE & Rd_Data2_i_EXE;
            ALUOP_W'(OP_OR):    w_alu = Rd_Data1_i_EXE | Rd_Data2_i_EXE;
            ALUOP_W'(OP_XOR):   w_alu = Rd_Data1_i_EXE ^ Rd_Data2_i_EXE;
            ALUOP_W'(OP_SLL):   w_alu = Rd_Data1_i_EXE << w_shamt;
            ALUOP_W'(OP_SRL):   w_alu = Rd_Data1_i_EXE >> w_shamt;
            ALUOP_W'(OP_SRA):   w_alu = $unsigned($signed(Rd_Data1_i_EXE) >>> w_shamt);
            ALUOP_W'(OP_SLT):   w_alu = {{(XLEN-1){1'b0}}, $signed(Rd_Data1_i_EXE) < $signed(Rd_Data2_i_EXE)};
            ALUOP_W'(OP_SLTU):  w_alu = {{(XLEN-1){1'b0}}, Rd_Data1_i_EXE < Rd_Data2_i_EXE};
            ALUOP_W'(OP_MUL):   w_is_mul = 1'b1;
            ALUOP_W'(OP_MULHU): begin
                w_is_mul   = 1'b1;
                w_is_mulhu = 1'b1;
            end
            default:            w_illegal = 1'b1;
        endcase
    end

    exe_mul_iter #(
        .XLEN(XLEN)
    ) u_mul (
        .clk        (clk_i_EXE),
        .rst_n      (rst_n_i_EXE),
        .i_start    (w_mul_start),
        .i_run      (w_mul_run),
        .i_a        (Rd_Data1_i_EXE),
        .i_b        (Rd_Data2_i_EXE),
        .o_done_c   (w_mul_done),
        .o_product_c(w_product)
    );

    // Next state and next output register contents; flush wins over everything.
    always_comb begin
        w_state_nxt     = r_state;
        w_out_valid_nxt = r_out_valid;
        w_wt_data_nxt   = r_wt_data;
        w_wt_addr_nxt   = r_wt_addr;
        w_wt_en_nxt     = r_wt_en;
        w_rd_data2_nxt  = r_rd_data2;
        w_illegal_nxt   = r_illegal;
        w_mulhu_nxt     = r_mulhu;
        w_mul_start     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_take) begin
                    w_out_valid_nxt = 1'b0;
                end
                if (w_accept) begin
                    w_wt_addr_nxt  = Wt_Addr_i_EXE;
                    w_rd_data2_nxt = Rd_Data2_i_EXE;
                    w_illegal_nxt  = w_illegal;
                    w_mulhu_nxt    = w_is_mulhu;
                    w_wt_en_nxt    = (regWrite_i_EXE && (Wt_Addr_i_EXE != '0) && !w_illegal) ? WEN_ON : WEN_OFF;
                    if (w_is_mul) begin
                        w_state_nxt = S_MUL_RUN;
                        w_mul_start = 1'b1;
                    end else begin
                        w_out_valid_nxt = 1'b1;
                        w_wt_data_nxt   = w_alu;
                    end
                end else if (r_out_valid && !out_ready_i_EXE) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_MUL_RUN: begin
                if (w_mul_done) begin
                    w_state_nxt     = S_HOLD;
                    w_out_valid_nxt = 1'b1;
                    w_wt_data_nxt   = r_mulhu ? w_product[2*XLEN-1:XLEN] : w_product[XLEN-1:0];
                end
            end
            S_HOLD: begin
                if (w_take) begin
                    w_state_nxt     = S_IDLE;
                    w_out_valid_nxt = 1'b0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush_i_EXE) begin
            w_state_nxt     = S_IDLE;
            w_out_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk_i_EXE or negedge rst_n_i_EXE) begin
        if (!rst_n_i_EXE) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_wt_data   <= '0;
            r_wt_addr   <= '0;
            r_wt_en     <= WEN_OFF;
            r_rd_data2  <= '0;
            r_illegal   <= 1'b0;
            r_mulhu     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_wt_data   <= w_wt_data_nxt;
            r_wt_addr   <= w_wt_addr_nxt;
            r_wt_en     <= w_wt_en_nxt;
            r_rd_data2  <= w_rd_data2_nxt;
            r_illegal   <= w_illegal_nxt;
            r_mulhu     <= w_mulhu_nxt;
        end
    end

    assign out_valid_o_EXE = r_out_valid;
    assign Wt_Data_o_EXE   = r_wt_data;
    assign Wt_Addr_o_EXE   = r_wt_addr;
    assign Wt_Enable_o_EXE = r_wt_en;
    assign Rd_Data2_o_EXE  = r_rd_data2;
    assign illegal_o_EXE   = r_illegal;
    assign busy_o_EXE      = (r_state == S_MUL_RUN);

endmodule

// File: tb/tb_exe_pipe.sv
// Directed bench for exe_pipe: a queue-based reference of accepted operations checked
// against every presented result, plus hand-computed literal expectations.
module tb_exe_pipe;
    import exe_pipe_pkg::*;

    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;
    localparam int unsigned OW   = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [OW-1:0]   op = '0;
    logic            regwrite = 1'b0;
    logic [XLEN-1:0] rs1 = '0, rs2 = '0, imm = '0;
    logic [RW-1:0]   rd = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] wt_data, rd2_o;
    logic [RW-1:0]   wt_addr;
    logic            wt_en, illegal, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exe_pipe dut (
        .clk_i_EXE          (clk),
        .rst_n_i_EXE        (rst_n),
        .flush_i_EXE        (flush),
        .in_valid_i_EXE     (in_valid),
        .in_ready_o_EXE     (in_ready),
        .ALUOp_i_EXE        (op),
        .regWrite_i_EXE     (regwrite),
        .Rd_Data1_i_EXE     (rs1),
        .Rd_Data2_i_EXE     (rs2),
        .immSignExtend_i_EXE(imm),
        .Wt_Addr_i_EXE      (rd),
        .out_valid_o_EXE    (out_valid),
        .out_ready_i_EXE    (out_ready),
        .Wt_Data_o_EXE      (wt_data),
        .Wt_Addr_o_EXE      (wt_addr),
        .Wt_Enable_o_EXE    (wt_en),
        .Rd_Data2_o_EXE     (rd2_o),
        .illegal_o_EXE      (illegal),
        .busy_o_EXE         (busy)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  addr;
        logic        en;
        logic [31:0] rd2;
        logic        ill;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // What the stage must produce for one accepted operation.
    function automatic exp_t model(input logic [7:0] o, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] im, input logic [4:0] d, input logic w);
        exp_t e;
        logic [63:0] p;
        p      = {32'd0, a} * {32'd0, b};
        e.data = '0;
        e.ill  = 1'b0;
        e.addr = d;
        e.rd2  = b;
        case (o)
            OP_ORI:   e.data = a | im;
            OP_ANDI:  e.data = a & im;
            OP_XORI:  e.data = a ^ im;
            OP_ADDI:  e.data = a + im;
            OP_ADD:   e.data = a + b;
            OP_SUB:   e.data = a - b;
            OP_AND:   e.data = a & b;
            OP_OR:    e.data = a | b;
            OP_XOR:   e.data = a ^ b;
            OP_SLL:   e.data = a << (b % 32);
            OP_SRL:   e.data = a >> (b % 32);
            OP_SRA:   e.data = 32'($signed(a) >>> (b % 32));
            OP_SLT:   e.data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU:  e.data = (a < b) ? 32'd1 : 32'd0;
            OP_MUL:   e.data = p[31:0];
            OP_MULHU: e.data = p[63:32];
            default:  e.ill = 1'b1;
        endcase
        e.en = w && (d != 5'd0) && !e.ill;
        return e;
    endfunction

    // Every cycle a result is presented it must match the oldest outstanding operation.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_valid: out_valid=1 with no outstanding operation");
                end else begin
                    chk("model_data", wt_data, q[0].data);
                    chk("model_addr", wt_addr, q[0].addr);
                    chk("model_en",   wt_en,   q[0].en);
                    chk("model_rd2",  rd2_o,   q[0].rd2);
                    chk("model_ill",  illegal, q[0].ill);
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (flush) q.delete();
            else if (in_valid && in_ready) q.push_back(model(op, rs1, rs2, imm, rd, regwrite));
        end
    end

    task automatic drive(input logic [7:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic [4:0] d, input logic w);
        op = o; rs1 = a; rs2 = b; imm = im; rd = d; regwrite = w; in_valid = 1'b1;
    endtask

    task automatic wait_accept();
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0 for 200 cycles, required 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] im, input logic [4:0] d, input logic w);
        drive(o, a, b, im, d, w);
        wait_accept();
    endtask

    task automatic run_mul(input logic [7:0] o, input logic [31:0] expd);
        int bc = 0;
        int vc = -1;
        send(o, 32'hFFFF_FFFF, 32'd2, 32'd0, 5'd5, 1'b1);
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (out_valid) begin
                vc = i;
                break;
            end
            if (busy) bc++;
        end
        chk("mul_busy_cycles", 64'(bc), 64'd32);
        chk("mul_valid_cycle", 64'(vc), 64'd33);
        chk("mul_busy_at_valid", busy, 1'b0);
        chk("mul_data", wt_data, expd);
        chk("mul_addr", wt_addr, 5'd5);
        chk("mul_en", wt_en, 1'b1);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [7:0]  o;
        logic [31:0] a, b, im;
        logic [4:0]  d;
        logic [31:0] e;
        logic        en;
    } vec_t;

    vec_t vecs[15] = '{
        '{OP_ORI,  32'h0000_00F0, 32'h0,          32'h0000_000F, 5'd3, 32'h0000_00FF, 1'b1},
        '{OP_ANDI, 32'h0000_F0F0, 32'h0,          32'h0000_00FF, 5'd1, 32'h0000_00F0, 1'b1},
        '{OP_XORI, 32'h0000_00FF, 32'h0,          32'h0000_000F, 5'd1, 32'h0000_00F0, 1'b1},
        '{OP_ADDI, 32'h0000_0010, 32'h0,          32'h0000_0005, 5'd0, 32'h0000_0015, 1'b0},
        '{OP_ADD,  32'hFFFF_FFFF, 32'h2,          32'h0,         5'd2, 32'h0000_0001, 1'b1},
        '{OP_SUB,  32'h0,         32'h1,          32'h0,         5'd2, 32'hFFFF_FFFF, 1'b1},
        '{OP_AND,  32'h0000_F0F0, 32'h0000_FF00,  32'h0,         5'd4, 32'h0000_F000, 1'b1},
        '{OP_OR,   32'h0000_F0F0, 32'h0000_0F0F,  32'h0,         5'd4, 32'h0000_FFFF, 1'b1},
        '{OP_XOR,  32'h0000_FF00, 32'h0000_0FF0,  32'h0,         5'd4, 32'h0000_F0F0, 1'b1},
        '{OP_SLL,  32'h1,         32'd31,         32'h0,         5'd6, 32'h8000_0000, 1'b1},
        '{OP_SLL,  32'h1,         32'd35,         32'h0,         5'd6, 32'h0000_0008, 1'b1},
        '{OP_SRL,  32'h8000_0000, 32'd4,          32'h0,         5'd6, 32'h0800_0000, 1'b1},
        '{OP_SRA,  32'h8000_0000, 32'd31,         32'h0,         5'd7, 32'hFFFF_FFFF, 1'b1},
        '{OP_SLT,  32'hFFFF_FFFF, 32'd1,          32'h0,         5'd7, 32'h0000_0001, 1'b1},
        '{OP_SLTU, 32'hFFFF_FFFF, 32'd1,          32'h0,         5'd7, 32'h0000_0000, 1'b1}
    };

    initial begin
        int nv;
        repeat (2) @(negedge clk);
        chk("rst_valid",   out_valid, 1'b0);
        chk("rst_ready",   in_ready,  1'b0);
        chk("rst_data",    wt_data,   32'h0);
        chk("rst_en",      wt_en,     1'b0);
        chk("rst_illegal", illegal,   1'b0);
        chk("rst_busy",    busy,      1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", in_ready, 1'b1);
        @(posedge clk); #1;
        out_ready = 1'b1;

        for (int i = 0; i < 15; i++) begin
            send(vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].im, vecs[i].d, 1'b1);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), out_valid, 1'b1);
            chk($sformatf("vec%0d_data", i),  wt_data,   vecs[i].e);
            chk($sformatf("vec%0d_addr", i),  wt_addr,   vecs[i].d);
            chk($sformatf("vec%0d_en", i),    wt_en,     vecs[i].en);
            @(posedge clk); #1;
        end

        for (int i = 0; i < 4; i++) begin
            drive(OP_ADD, 32'(i), 32'd100, 32'd0, 5'd9, 1'b1);
            @(negedge clk);
            chk("b2b_ready", in_ready, 1'b1);
            if (i > 0) chk("b2b_valid", out_valid, 1'b1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_last_data", wt_data, 32'd103);
        @(posedge clk); #1;

        run_mul(OP_MUL,   32'hFFFF_FFFE);
        run_mul(OP_MULHU, 32'h0000_0001);

        out_ready = 1'b0;
        send(OP_ADD, 32'd5, 32'd7, 32'd0, 5'd7, 1'b1);
        drive(OP_SUB, 32'd5, 32'd7, 32'd0, 5'd8, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_data",  wt_data,   32'd12);
            chk("hold_ready", in_ready,  1'b0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_accept();
        @(negedge clk);
        chk("sub_valid", out_valid, 1'b1);
        chk("sub_data",  wt_data,   32'hFFFF_FFFE);
        chk("sub_addr",  wt_addr,   5'd8);
        @(posedge clk); #1;

        send(8'hFF, 32'd1, 32'd2, 32'd3, 5'd4, 1'b1);
        @(negedge clk);
        chk("ill_valid", out_valid, 1'b1);
        chk("ill_flag",  illegal,   1'b1);
        chk("ill_en",    wt_en,     1'b0);
        chk("ill_data",  wt_data,   32'h0);
        @(posedge clk); #1;

        send(OP_MUL, 32'd3, 32'd4, 32'd0, 5'd6, 1'b1);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_busy",  busy,      1'b0);
        chk("flush_ready", in_ready,  1'b1);
        nv = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        chk("flush_no_result", 64'(nv), 64'd0);
        @(posedge clk); #1;
        drive(OP_ADD, 32'd1, 32'd1, 32'd0, 5'd3, 1'b1);
        flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_drops_accept", out_valid, 1'b0);
        @(posedge clk); #1;

        send(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 5'd7, 1'b1);
        repeat (19) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_busy",  busy,      1'b0);
        chk("midrst_ready", in_ready,  1'b0);
        chk("midrst_addr",  wt_addr,   5'd0);
        chk("midrst_rd2",   rd2_o,     32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready_after", in_ready, 1'b1);
        nv = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        chk("midrst_no_result", 64'(nv), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
